fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit that replaces the single-stage, purely combinational bypass.
- Holds a DEPTH-entry shift history of in-flight register writes (rd, data, data-ready).
- Resolves NREAD source operands against that history, youngest match first.
- Flags load-use hazards with stall_req and keeps saturating forward/stall event counters. Sits between decode operand read and the execute stage.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width.
- DEPTH, 3, number of tracked in-flight write stages (entry 0 youngest). Valid range 1..8.
- NREAD, 2, number of source-operand read ports.
- CW, 16, event counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline hold; history does not advance.
- flush  in  1  synchronous clear of all history entries.
- ex_valid  in  1  instruction entering history this cycle writes a register.
- ex_rd  in  AW  destination register of the entering instruction.
- ex_data  in  XLEN  result of the entering instruction, meaningful when ex_ready=1.
- ex_ready  in  1  0 = load, data arrives later on the fill port.
- fill_valid  in  1  load data return.
- fill_rd  in  AW  destination register of the returning load.
- fill_data  in  XLEN  load data.
- rs_addr  in  NREAD*AW  packed source addresses; port i occupies bits [i*AW +: AW].
- rf_data  in  NREAD*XLEN  register-file read data, packed the same way.
- fwd_data  out  NREAD*XLEN  resolved operands.
- fwd_hit  out  NREAD  per-port forward taken.
- stall_req  out  1  an operand depends on a not-yet-ready load.
- fwd_count  out  CW  saturating count of forward events.
- stall_count  out  CW  saturating count of stall_req cycles.

Behaviour:
- Entry fields: v, rd, data, rdy.
- Reset (async, high): all v=0, rdy=0, data=0, both counters 0.
  - Outputs during reset: fwd_data=rf_data, fwd_hit=0, stall_req=0.
- Advance occurs on a clk edge with !stall && !flush.
  - entry[k] <= entry[k-1] for k=1..DEPTH-1.
  - entry[0] <= {ex_valid && ex_rd!=0, ex_rd, ex_data, ex_ready}.
  - entry[DEPTH-1] is discarded; the register file holds its value by then.
- stall=1: entries hold; the fill port remains active.
- flush=1 (priority over stall): all v<=0. Counters are not cleared.
- Fill: on fill_valid, the youngest entry with v && !rdy && rd==fill_rd takes data<=fill_data, rdy<=1.
  - Applied after the shift in the same edge, so it targets the post-shift position.
  - No match: fill ignored.
  - fill_rd==0: ignored.
- Lookup (combinational from registered state), per port i:
  - If rs_addr[i]==0: fwd_data[i]=rf_data[i], fwd_hit[i]=0.
  - Otherwise find the lowest k with v && rd==rs_addr[i].
  - Match with rdy=1: fwd_data=data, fwd_hit=1.
  - Match with rdy=0: fwd_data=rf_data, fwd_hit=0, and the port contributes to stall_req.
  - No match: fwd_data=rf_data, fwd_hit=0.
  - Older matches are masked by younger ones, including by a younger not-ready match.
- stall_req = OR over ports of a not-ready youngest match.
  - The pipeline controller responds with stall or a bubble (ex_valid=0); the block does not gate itself.
- Counters: on each edge where !stall, fwd_count += popcount(fwd_hit).
  - stall_count += 1 on each edge where stall_req=1, independent of stall.
  - Both saturate at 2^CW-1.
- Same-cycle write and read: a value entering on ex_* is not visible to lookup until the next cycle (no combinational ex→fwd path).

Test Plan:
- Reset mid-operation: fill history, assert reset asynchronously between edges -> fwd_hit=0, fwd_data==rf_data, stall_req=0, counters 0 immediately, without waiting for a clock edge.
- Youngest priority: issue x5=0x11, then x5=0x22, then rs_addr port0=5 -> fwd_data[0]=0x22, fwd_hit[0]=1. After DEPTH further bubbles -> fwd_hit=0, fwd_data=rf_data.
- x0 and port independence: issue x0=0xDEAD, read rs=0 on port0 and rs=7 (no match) on port1 -> both return rf_data, hit=0.
- Load-use: issue load x3 (ex_ready=0), read rs=3 -> stall_req=1 and stall_count increments. Hold stall, apply fill x3=0xCAFE -> next cycle stall_req=0, fwd_data=0xCAFE.
- Stall hold and flush: stall=1 for 3 cycles -> lookup unchanged, no shift, fwd_count unchanged. Then flush=1 with stall=1 -> all hits clear next cycle.
- Saturation: CW=4, forward on both ports for 10 cycles -> fwd_count holds at 15.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and load-use hazard unit. A short shift history of in-flight
// register writes feeds a youngest-first bypass onto each source read port.
module fwd_scoreboard #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NREAD = 2,
  parameter int CW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [AW-1:0]         ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  ex_ready,
  input  logic                  fill_valid,
  input  logic [AW-1:0]         fill_rd,
  input  logic [XLEN-1:0]       fill_data,
  input  logic [NREAD*AW-1:0]   rs_addr,
  input  logic [NREAD*XLEN-1:0] rf_data,
  output logic [NREAD*XLEN-1:0] fwd_data,
  output logic [NREAD-1:0]      fwd_hit,
  output logic                  stall_req,
  output logic [CW-1:0]         fwd_count,
  output logic [CW-1:0]         stall_count
);

  localparam int PCW = $clog2(NREAD + 1);

  logic            v_reg    [DEPTH];
  logic [AW-1:0]   rd_reg   [DEPTH];
  logic [XLEN-1:0] data_reg [DEPTH];
  logic            rdy_reg  [DEPTH];

  logic            v_next    [DEPTH];
  logic [AW-1:0]   rd_next   [DEPTH];
  logic [XLEN-1:0] data_next [DEPTH];
  logic            rdy_next  [DEPTH];

  logic            fill_taken;
  logic [NREAD-1:0] pend_vec;

  logic [CW-1:0]   fwd_count_reg, fwd_count_next;
  logic [CW-1:0]   stall_count_reg, stall_count_next;
  logic [PCW-1:0]  hit_cnt;
  logic [CW:0]     fwd_sum;

  // History update: shift (or hold), then fill lands on the post-shift image,
  // then flush clears every valid bit.
  always_comb begin
    fill_taken = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      v_next[k]    = v_reg[k];
      rd_next[k]   = rd_reg[k];
      data_next[k] = data_reg[k];
      rdy_next[k]  = rdy_reg[k];
    end
    if (!stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v_next[k]    = v_reg[k-1];
        rd_next[k]   = rd_reg[k-1];
        data_next[k] = data_reg[k-1];
        rdy_next[k]  = rdy_reg[k-1];
      end
      v_next[0]    = ex_valid && (ex_rd != '0);
      rd_next[0]   = ex_rd;
      data_next[0] = ex_data;
      rdy_next[0]  = ex_ready;
    end
    if (fill_valid && (fill_rd != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!fill_taken && v_next[k] && !rdy_next[k] && (rd_next[k] == fill_rd)) begin
          data_next[k] = fill_data;
          rdy_next[k]  = 1'b1;
          fill_taken   = 1'b1;
        end
      end
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_reg[k]    <= 1'b0;
        rd_reg[k]   <= '0;
        data_reg[k] <= '0;
        rdy_reg[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        v_reg[k]    <= v_next[k];
        rd_reg[k]   <= rd_next[k];
        data_reg[k] <= data_next[k];
        rdy_reg[k]  <= rdy_next[k];
      end
    end
  end

  // Per-port lookup; scanning oldest to youngest lets the youngest match win,
  // including a not-ready one that masks an older ready value.
  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
      logic [AW-1:0]   rs;
      logic [XLEN-1:0] rf;
      logic [XLEN-1:0] sel;
      logic            hit;
      logic            pend;

      assign rs = rs_addr[gi*AW +: AW];
      assign rf = rf_data[gi*XLEN +: XLEN];

      always_comb begin
        sel  = rf;
        hit  = 1'b0;
        pend = 1'b0;
        if (rs != '0) begin
          for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_reg[k] && (rd_reg[k] == rs)) begin
              if (rdy_reg[k]) begin
                sel  = data_reg[k];
                hit  = 1'b1;
                pend = 1'b0;
              end else begin
                sel  = rf;
                hit  = 1'b0;
                pend = 1'b1;
              end
            end
          end
        end
      end

      assign fwd_data[gi*XLEN +: XLEN] = sel;
      assign fwd_hit[gi]               = hit;
      assign pend_vec[gi]              = pend;
    end
  endgenerate

  assign stall_req = |pend_vec;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NREAD; i++) begin
      hit_cnt = hit_cnt + PCW'(fwd_hit[i]);
    end
  end

  assign fwd_sum = {1'b0, fwd_count_reg} + (CW+1)'(hit_cnt);

  always_comb begin
    fwd_count_next   = fwd_count_reg;
    stall_count_next = stall_count_reg;
    if (!stall) begin
      fwd_count_next = fwd_sum[CW] ? '1 : fwd_sum[CW-1:0];
    end
    if (stall_req && (stall_count_reg != '1)) begin
      stall_count_next = stall_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count_reg   <= '0;
      stall_count_reg <= '0;
    end else begin
      fwd_count_reg   <= fwd_count_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign fwd_count   = fwd_count_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: priority, x0, load-use fill, stall/flush,
// counter saturation (CW=4) and asynchronous reset in mid-operation.
module tb_fwd_scoreboard;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NREAD = 2;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  stall, flush;
  logic                  ex_valid, ex_ready;
  logic [AW-1:0]         ex_rd;
  logic [XLEN-1:0]       ex_data;
  logic                  fill_valid;
  logic [AW-1:0]         fill_rd;
  logic [XLEN-1:0]       fill_data;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rf_data;
  logic [NREAD*XLEN-1:0] fwd_data;
  logic [NREAD-1:0]      fwd_hit;
  logic                  stall_req;
  logic [CW-1:0]         fwd_count, stall_count;

  int errors = 0;
  int checks = 0;

  localparam logic [XLEN-1:0] RF0 = 32'hAAAA_0000;
  localparam logic [XLEN-1:0] RF1 = 32'hBBBB_0001;

  fwd_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NREAD(NREAD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .fill_valid(fill_valid), .fill_rd(fill_rd), .fill_data(fill_data),
    .rs_addr(rs_addr), .rf_data(rf_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
    .stall_req(stall_req), .fwd_count(fwd_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d, input logic rdy);
    ex_valid = v;
    ex_rd    = rd;
    ex_data  = d;
    ex_ready = rdy;
  endtask

  task automatic read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr = {a1, a0};
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    issue(1'b0, '0, '0, 1'b1);
    fill_valid = 1'b0; fill_rd = '0; fill_data = '0;
    read(5'd0, 5'd0);
    rf_data = {RF1, RF0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit", 32'(fwd_hit), 32'd0);
    check("rst_stall_req", 32'(stall_req), 32'd0);
    check("rst_fwd_count", 32'(fwd_count), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    reset = 1'b0;

    // Youngest priority: x5=0x11 then x5=0x22
    issue(1'b1, 5'd5, 32'h11, 1'b1);
    tick();
    issue(1'b1, 5'd5, 32'h22, 1'b1);
    tick();
    issue(1'b0, '0, '0, 1'b1);
    read(5'd5, 5'd0);
    #1;
    check("young_data0", fwd_data[31:0], 32'h22);
    check("young_hit", 32'(fwd_hit), 32'd1);
    check("young_data1", fwd_data[63:32], RF1);
    tick();
    check("young_after1", fwd_data[31:0], 32'h22);
    tick();
    tick();
    check("aged_hit", 32'(fwd_hit), 32'd0);
    check("aged_data0", fwd_data[31:0], RF0);
    check("aged_fwd_count", 32'(fwd_count), 32'd3);

    // x0 write is never tracked; unmatched port falls through
    issue(1'b1, 5'd0, 32'hDEAD, 1'b1);
    read(5'd0, 5'd7);
    tick();
    issue(1'b0, '0, '0, 1'b1);
    #1;
    check("x0_data0", fwd_data[31:0], RF0);
    check("x0_data1", fwd_data[63:32], RF1);
    check("x0_hit", 32'(fwd_hit), 32'd0);

    // Load-use on x3, resolved by fill while stalled
    issue(1'b1, 5'd3, 32'h0, 1'b0);
    read(5'd3, 5'd7);
    tick();
    issue(1'b0, '0, '0, 1'b1);
    #1;
    check("lu_stall_req", 32'(stall_req), 32'd1);
    check("lu_hit", 32'(fwd_hit), 32'd0);
    check("lu_data0", fwd_data[31:0], RF0);
    stall = 1'b1;
    tick();
    check("lu_stall_count1", 32'(stall_count), 32'd1);
    fill_valid = 1'b1; fill_rd = 5'd3; fill_data = 32'hCAFE;
    tick();
    fill_valid = 1'b0;
    #1;
    check("fill_stall_req", 32'(stall_req), 32'd0);
    check("fill_data0", fwd_data[31:0], 32'hCAFE);
    check("fill_hit", 32'(fwd_hit), 32'd1);
    check("fill_stall_count", 32'(stall_count), 32'd2);
    check("fill_fwd_count", 32'(fwd_count), 32'd3);

    // Stall hold: a presented ex write must not shift in
    issue(1'b1, 5'd3, 32'h99, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_data0_%0d", i), fwd_data[31:0], 32'hCAFE);
    end
    check("hold_fwd_count", 32'(fwd_count), 32'd3);

    // Flush beats stall
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    issue(1'b0, '0, '0, 1'b1);
    #1;
    check("flush_hit", 32'(fwd_hit), 32'd0);
    check("flush_data0", fwd_data[31:0], RF0);
    check("flush_fwd_count", 32'(fwd_count), 32'd3);
    check("flush_stall_count", 32'(stall_count), 32'd2);

    // Younger not-ready x4 masks older ready x4; fill targets post-shift slot
    issue(1'b1, 5'd4, 32'h44, 1'b1);
    tick();
    issue(1'b1, 5'd4, 32'h0, 1'b0);
    tick();
    issue(1'b0, '0, '0, 1'b1);
    read(5'd4, 5'd7);
    #1;
    check("mask_stall_req", 32'(stall_req), 32'd1);
    check("mask_hit", 32'(fwd_hit), 32'd0);
    fill_valid = 1'b1; fill_rd = 5'd4; fill_data = 32'h55;
    tick();
    fill_valid = 1'b0;
    #1;
    check("mask_fill_data0", fwd_data[31:0], 32'h55);
    check("mask_fill_req", 32'(stall_req), 32'd0);
    check("mask_stall_count", 32'(stall_count), 32'd3);

    // Saturation: x9 forwarded on both ports every cycle
    issue(1'b1, 5'd9, 32'h90, 1'b1);
    read(5'd9, 5'd9);
    tick();
    check("sat_start", 32'(fwd_count), 32'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) check("sat_mid", 32'(fwd_count), 32'd13);
    end
    check("sat_end", 32'(fwd_count), 32'd15);
    check("sat_data1", fwd_data[63:32], 32'h90);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_hit", 32'(fwd_hit), 32'd0);
    check("async_data0", fwd_data[31:0], RF0);
    check("async_data1", fwd_data[63:32], RF1);
    check("async_stall_req", 32'(stall_req), 32'd0);
    check("async_fwd_count", 32'(fwd_count), 32'd0);
    check("async_stall_count", 32'(stall_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
